// File: rtl/udp_pkg.sv
// Shared constants, state encoding and header byte selection for the UDP header inserter.
package udp_pkg;

  localparam int unsigned UDP_HDR_LEN = 8;

  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd5000;
  localparam logic [15:0] DEFAULT_DST_PORT = 16'd5001;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHdr,
    StPayload
  } udp_state_e;

  // Header byte idx of an 8-byte UDP header; the checksum (bytes 6-7) is left at zero.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] src_port,
                                          input logic [15:0] dst_port,
                                          input logic [15:0] len);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = src_port[15:8];
      3'd1:    b = src_port[7:0];
      3'd2:    b = dst_port[15:8];
      3'd3:    b = dst_port[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_header_inserter_byte_buffer.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module byte_buffer #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_header_inserter.sv
// Buffers a payload burst, then streams an 8-byte UDP header followed by the payload.
module udp_header_inserter
  import udp_pkg::*;
#(
  parameter logic [15:0] SRC_PORT    = DEFAULT_SRC_PORT,
  parameter logic [15:0] DST_PORT    = DEFAULT_DST_PORT,
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(MAX_PAYLOAD);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_PAYLOAD);
  localparam logic [2:0] HDR_LAST = 3'(UDP_HDR_LEN - 1);

  udp_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    hdr_idx_q, hdr_idx_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          overflow_q, overflow_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    rdata;
  logic [15:0]   len;
  logic          fire;

  assign len  = 16'(count_q) + 16'(UDP_HDR_LEN);
  assign fire = out_valid_q && out_ready;

  // Read address follows the next pointer so rdata always holds buffer[rd_ptr_q].
  byte_buffer #(
    .DEPTH (MAX_PAYLOAD)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (in_data),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    hdr_idx_d   = hdr_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    we          = 1'b0;
    waddr       = count_q[AW-1:0];

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          we       = 1'b1;
          waddr    = '0;
          count_d  = CW'(1);
          rd_ptr_d = '0;
          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (in_valid) begin
          if (count_q == COUNT_MAX) begin
            overflow_d = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d     = StHdr;
          hdr_idx_d   = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = hdr_byte(3'd0, SRC_PORT, DST_PORT, len);
        end
      end
      StHdr: begin
        if (in_valid) overflow_d = 1'b1;
        if (fire) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d    = StPayload;
            out_data_d = rdata;
            out_last_d = (count_q == CW'(1));
            rd_ptr_d   = CW'(1);
          end else begin
            hdr_idx_d  = hdr_idx_q + 3'd1;
            out_data_d = hdr_byte(hdr_idx_q + 3'd1, SRC_PORT, DST_PORT, len);
          end
        end
      end
      StPayload: begin
        if (in_valid) overflow_d = 1'b1;
        if (fire) begin
          if (out_last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            count_d     = '0;
            rd_ptr_d    = '0;
          end else begin
            out_data_d = rdata;
            out_last_d = (rd_ptr_q == count_q - CW'(1));
            rd_ptr_d   = rd_ptr_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      hdr_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      hdr_idx_q   <= hdr_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == StHdr) || (state_q == StPayload);

endmodule

// File: doc/udp_header_inserter.md
Name: udp_header_inserter

Overview:
- Downstream neighbour of the payload byte source on the UDP transmit path.
- Captures a burst of payload bytes (valid-strobe interface, no backpressure) into an internal buffer and counts them.
- Emits an 8-byte UDP header (src port, dst port, length, checksum = 0), then the buffered payload, on a valid/ready byte stream with a last marker for the next framing stage.

Parameters:
- SRC_PORT, 16'd5000, UDP source port placed in header bytes 0-1.
- DST_PORT, 16'd5001, UDP destination port placed in header bytes 2-3.
- MAX_PAYLOAD, 64, payload buffer depth in bytes; power of 2, range 2..1024.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  payload byte, sampled when in_valid = 1.
- in_valid  in  1  payload strobe; one byte per cycle; a burst ends on the first cycle in_valid = 0.
- out_data  out  8  header/payload byte, registered.
- out_valid  out  1  out_data is valid, registered.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_last  out  1  high with the final payload byte of a datagram, registered.
- busy  out  1  high in states HDR and PAYLOAD.
- overflow  out  1  sticky flag: at least one input byte was dropped; cleared only by rst.

Behaviour:
- Reset (async): state = IDLE; out_valid = 0, out_last = 0, out_data = 0, busy = 0, overflow = 0; byte count and read pointer = 0. Any in-progress datagram is discarded.
- States and transitions:
  - IDLE: in_valid = 1 writes the byte at address 0, count = 1, go to COLLECT.
  - COLLECT: in_valid = 1 writes the byte at address count and increments count. If count == MAX_PAYLOAD, the byte is dropped, overflow is set and count is held.
  - COLLECT to HDR: on the edge where in_valid is sampled 0. On that same edge, out_valid = 1 and out_data = SRC_PORT[15:8]. Header latency is therefore one cycle after the last payload byte's sampling edge.
  - HDR: 8 bytes in order:
    - SRC_PORT[15:8], SRC_PORT[7:0]
    - DST_PORT[15:8], DST_PORT[7:0]
    - LEN[15:8], LEN[7:0], where LEN = count + 8 as 16-bit unsigned, zero-extended from count
    - 8'h00, 8'h00
  - HDR to PAYLOAD: on the handshake of header byte 7, out_data = buffer[0] is presented on the next cycle.
  - PAYLOAD: bytes buffer[0..count-1]; out_last = 1 only with buffer[count-1].
  - PAYLOAD to IDLE: on the handshake of the last byte, out_valid = 0 and out_last = 0 on that edge. No gap cycles are required between header and payload.
- Handshake rules:
  - out_data and out_last advance only on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_valid and out_last hold stable.
  - out_valid never drops without a handshake, except on rst.
- in_valid = 1 while busy: the byte is dropped and overflow is set; datagram output is unaffected. A new burst starts only in IDLE.
- Zero-length datagrams cannot occur: count ≥ 1 on entering HDR.
- Buffer reads are synchronous. The implementation prefetches so that the registered out_data meets the zero-bubble requirement.
- count width is clog2(MAX_PAYLOAD)+1 bits. For MAX_PAYLOAD = 64 the maximum LEN is 16'h0048.

Decomposition:
- Package udp_pkg:
  - UDP_HDR_LEN = 8
  - state encoding IDLE/COLLECT/HDR/PAYLOAD (2 bits)
  - default port constants 5000/5001
  - function for header byte select by index 0..7
- Sub-module byte_buffer: simple dual-port RAM, one write port and one synchronous read port, parameter DEPTH, 8-bit data. Instantiated once.

Test Plan:
- 11-byte burst 48 65 6C 6C 6F 20 57 6F 72 6C 64, out_ready = 1 -> 19 bytes: 13 88 13 89 00 13 00 00 then the payload; out_last only on 0x64; first out_valid one cycle after in_valid falls; no bubbles; overflow = 0.
- Same burst with out_ready randomly toggled (~50%) -> identical 19-byte sequence; out_data/out_last held stable during every stall cycle.
- 70-byte burst 0x00..0x45, MAX_PAYLOAD = 64 -> LEN bytes 00 48; payload 0x00..0x3F; overflow = 1 and stays 1 after the frame.
- 1-byte burst 0xAA -> 13 88 13 89 00 09 00 00 AA, out_last with 0xAA; then a 2-byte burst 01 02 is accepted afterwards with LEN = 00 0A.
- in_valid pulsed during HDR and during PAYLOAD -> those bytes are absent from the output; current frame unchanged; overflow = 1.
- rst asserted mid-PAYLOAD -> out_valid/out_last/busy go 0 immediately (async); after release, the 11-byte burst again produces the exact 19-byte sequence of scenario 1.
